// File: rtl/softmax_seq.sv
// Sequential softmax over NUM_CLASSES lanes: max search, exponent lookup with
// running sum, then a restoring divider per lane producing saturated
// fixed-point probabilities with 2^OUT_BITS as the unit.
module softmax_seq #(
  parameter int NUM_CLASSES   = 4,
  parameter int DATA_BITS     = 8,
  parameter int OUT_BITS      = 8,
  parameter int EXP_BITS      = 8,
  parameter int LUT_ADDR_BITS = 8,
  parameter int EXP_SCALE     = 32,
  parameter int SIGNED_IN     = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CLASSES*DATA_BITS-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_CLASSES*OUT_BITS-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy
);

  localparam int SUM_BITS  = EXP_BITS + $clog2(NUM_CLASSES);
  localparam int LANE_BITS = $clog2(NUM_CLASSES);
  localparam int STEP_BITS = $clog2(OUT_BITS + 1);
  localparam int LUT_SIZE  = 1 << LUT_ADDR_BITS;
  localparam int DIFF_BITS = DATA_BITS + 1;
  localparam int REM_BITS  = SUM_BITS + OUT_BITS + 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MAX  = 3'd1;
  localparam logic [2:0] EXP  = 3'd2;
  localparam logic [2:0] DIV  = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  // exp(-k/EXP_SCALE) scaled to full EXP_BITS range; exp(y) is evaluated as
  // a short series on y/256 and squared eight times to stay accurate.
  function automatic logic [EXP_BITS-1:0] exp_entry(input int k);
    real y, term, s, scale;
    y = real'(k) / (real'(EXP_SCALE) * 256.0);
    s = 1.0;
    term = 1.0;
    for (int n = 1; n < 16; n++) begin
      term = term * y / real'(n);
      s = s + term;
    end
    for (int n = 0; n < 8; n++) s = s * s;
    scale = real'((1 << EXP_BITS) - 1);
    return EXP_BITS'($rtoi(scale / s + 0.5));
  endfunction

  logic [EXP_BITS-1:0] lut [LUT_SIZE];

  for (genvar gi = 0; gi < LUT_SIZE; gi++) begin : g_lut
    localparam logic [EXP_BITS-1:0] ENTRY = exp_entry(gi);
    assign lut[gi] = ENTRY;
  end

  logic [2:0]                       state_reg;
  logic [NUM_CLASSES*DATA_BITS-1:0] cap_reg;
  logic [DATA_BITS-1:0]             max_reg;
  logic [LANE_BITS-1:0]             lane_reg;
  logic [STEP_BITS-1:0]             step_reg;
  logic [SUM_BITS-1:0]              sum_reg;
  logic [EXP_BITS-1:0]              e_reg [NUM_CLASSES];
  logic [OUT_BITS-1:0]              res_reg [NUM_CLASSES];
  logic [REM_BITS-1:0]              rem_reg;
  logic [OUT_BITS:0]                q_reg;
  logic [NUM_CLASSES*OUT_BITS-1:0]  out_data_reg;
  logic                             out_valid_reg;

  logic                             lane_last, step_last;
  logic [DATA_BITS-1:0]             x_sel;
  logic                             x_gt_max;
  logic [DIFF_BITS-1:0]             x_ext, max_ext, diff;
  logic [31:0]                      diff32;
  logic [LUT_ADDR_BITS-1:0]         lut_addr;
  logic [EXP_BITS-1:0]              e_sel;
  logic [REM_BITS-1:0]              cur_rem, cur_div, rem_next;
  logic                             ge;
  logic [OUT_BITS:0]                q_next;
  logic [OUT_BITS-1:0]              q_sat;
  logic [NUM_CLASSES*OUT_BITS-1:0]  out_assembled;

  assign lane_last = (lane_reg == LANE_BITS'(NUM_CLASSES - 1));
  assign step_last = (step_reg == STEP_BITS'(OUT_BITS));
  assign x_sel     = cap_reg[int'(lane_reg)*DATA_BITS +: DATA_BITS];

  // Lane compare, distance from the max, clamped LUT address and divider step
  always_comb begin
    x_ext   = (SIGNED_IN != 0) ? {x_sel[DATA_BITS-1], x_sel} : {1'b0, x_sel};
    max_ext = (SIGNED_IN != 0) ? {max_reg[DATA_BITS-1], max_reg} : {1'b0, max_reg};
    x_gt_max = (SIGNED_IN != 0) ? ($signed(x_ext) > $signed(max_ext)) : (x_ext > max_ext);
    diff    = max_ext - x_ext;
    diff32  = 32'(diff);
    if (diff32 > 32'(LUT_SIZE - 1)) lut_addr = '1;
    else                            lut_addr = LUT_ADDR_BITS'(diff32);
    e_sel   = lut[lut_addr];

    // Step s tests quotient bit OUT_BITS-s; the dividend is loaded on step 0
    cur_rem  = (step_reg == '0) ? (REM_BITS'(e_reg[lane_reg]) << OUT_BITS) : rem_reg;
    cur_div  = REM_BITS'(sum_reg) << (OUT_BITS - int'(step_reg));
    ge       = (cur_rem >= cur_div);
    rem_next = ge ? (cur_rem - cur_div) : cur_rem;
    q_next   = (step_reg == '0) ? {{OUT_BITS{1'b0}}, ge} : {q_reg[OUT_BITS-1:0], ge};
    q_sat    = q_next[OUT_BITS] ? '1 : q_next[OUT_BITS-1:0];
  end

  // The last lane's quotient is still combinational on the edge entering OUT
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_out
    assign out_assembled[gi*OUT_BITS +: OUT_BITS] = (gi == NUM_CLASSES - 1) ? q_sat : res_reg[gi];
  end

  // Main FSM with datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cap_reg       <= '0;
      max_reg       <= '0;
      lane_reg      <= '0;
      step_reg      <= '0;
      sum_reg       <= '0;
      rem_reg       <= '0;
      q_reg         <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        e_reg[i]   <= '0;
        res_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            cap_reg   <= in_data;
            lane_reg  <= '0;
            sum_reg   <= '0;
            state_reg <= MAX;
          end
        end
        MAX: begin
          if (lane_reg == '0 || x_gt_max) max_reg <= x_sel;
          if (lane_last) begin
            lane_reg  <= '0;
            state_reg <= EXP;
          end else begin
            lane_reg <= lane_reg + LANE_BITS'(1);
          end
        end
        EXP: begin
          e_reg[lane_reg] <= e_sel;
          sum_reg         <= sum_reg + SUM_BITS'(e_sel);
          if (lane_last) begin
            lane_reg  <= '0;
            step_reg  <= '0;
            state_reg <= DIV;
          end else begin
            lane_reg <= lane_reg + LANE_BITS'(1);
          end
        end
        DIV: begin
          rem_reg <= rem_next;
          q_reg   <= q_next;
          if (step_last) begin
            res_reg[lane_reg] <= q_sat;
            step_reg          <= '0;
            if (lane_last) begin
              lane_reg      <= '0;
              out_data_reg  <= out_assembled;
              out_valid_reg <= 1'b1;
              state_reg     <= OUT;
            end else begin
              lane_reg <= lane_reg + LANE_BITS'(1);
            end
          end else begin
            step_reg <= step_reg + STEP_BITS'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign busy      = (state_reg != IDLE);
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_softmax_seq.sv
// Scoreboard bench for softmax_seq: an unsigned instance driven through a
// queue of model results, plus a signed instance for the two's complement case.
module tb_softmax_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic [31:0] in_data_s;
  logic        in_valid_s;
  logic        in_ready_s;
  logic [31:0] out_data_s;
  logic        out_valid_s;
  logic        out_ready_s;
  logic        busy_s;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  softmax_seq dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  softmax_seq #(.SIGNED_IN(1)) dut_s (
    .clk(clk), .rst(rst), .in_data(in_data_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready_s), .busy(busy_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Reference softmax straight from the math, 4 lanes of 8 bits
  function automatic logic [31:0] model(input logic [31:0] v, input bit sgn);
    int x[4];
    int e[4];
    int mx, d, sum, q;
    logic [7:0] b;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      b = v[i*8 +: 8];
      x[i] = sgn ? int'($signed(b)) : int'(b);
    end
    mx = x[0];
    for (int i = 1; i < 4; i++) if (x[i] > mx) mx = x[i];
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      d = mx - x[i];
      if (d > 255) d = 255;
      e[i] = $rtoi(255.0 * $exp(-real'(d) / 32.0) + 0.5);
      sum += e[i];
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      q = (e[i] * 256) / sum;
      if (q > 255) q = 255;
      r[i*8 +: 8] = 8'(q);
    end
    return r;
  endfunction

  // One vector through the unsigned DUT; bp > 0 holds out_ready low that many cycles
  task automatic run_vec(input logic [31:0] v, input int bp, input string tag);
    int cnt;
    logic [31:0] held;
    logic [31:0] expv;
    @(negedge clk);
    out_ready = (bp == 0);
    in_data   = v;
    in_valid  = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(v, 1'b0));
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, " latency"}, 64'(cnt), 64'd44);
    expv = exp_q.pop_front();
    check({tag, " data"}, 64'(out_data), 64'(expv));
    held = out_data;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clk);
      #1;
      check({tag, " hold valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold data"}, 64'(out_data), 64'(held));
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    if (bp > 0) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " valid drop"}, 64'(out_valid), 64'd0);
    check({tag, " idle ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int cnt;
    int seen;
    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    in_data_s = '0; in_valid_s = 1'b0; out_ready_s = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post rst in_ready", 64'(in_ready), 64'd1);

    run_vec(32'h8080_8080, 0, "uniform128");
    check("uniform128 const", 64'(model(32'h8080_8080, 1'b0)), 64'h4040_4040);
    run_vec(32'h0000_0000, 0, "uniform0");
    run_vec(32'h4080_C0FF, 0, "graded");
    check("graded const", 64'(model(32'h4080_C0FF, 1'b0)), 64'h0004_1FDB);
    run_vec(32'hFF10_FF20, 0, "ties");
    run_vec(32'h3C5A_1E7F, 0, "mixed");
    run_vec($urandom, 10, "backpressure");

    // Abort a vector in DIV with an asynchronous reset
    @(negedge clk);
    in_data  = 32'h1122_3344;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort no output", 64'(seen), 64'd0);
    run_vec(32'h8080_8080, 0, "after abort");

    // Signed instance: one saturated winner
    @(negedge clk);
    in_data_s  = 32'h8080_807F;
    in_valid_s = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s = 1'b0;
    cnt = 0;
    while (!out_valid_s && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("signed latency", 64'(cnt), 64'd44);
    check("signed data", 64'(out_data_s), 64'h0000_00FF);
    check("signed model", 64'(out_data_s), 64'(model(32'h8080_807F, 1'b1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/softmax_seq.md
SOFTMAX_SEQ -- requirements
Module: softmax_seq

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 4, number of input lanes (>=2).
REQ-002 SHALL have parameter DATA_BITS, default 8, width of each input lane.
REQ-003 SHALL have parameter OUT_BITS, default 8, width of each output probability lane.
REQ-004 SHALL have parameter EXP_BITS, default 8, width of each exponent LUT entry.
REQ-005 SHALL have parameter LUT_ADDR_BITS, default 8, exponent LUT address width.
REQ-006 SHALL have parameter EXP_SCALE, default 32, input counts per natural-log unit.
REQ-007 SHALL have parameter SIGNED_IN, default 0, 1 = lanes are two's complement.
REQ-008 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-009 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port in_data, input, NUM_CLASSES*DATA_BITS, lane i at [i*DATA_BITS +: DATA_BITS].
REQ-011 SHALL have ports in_valid (input, 1) and in_ready (output, 1), input handshake.
REQ-012 SHALL have port out_data, output, NUM_CLASSES*OUT_BITS, lane i at [i*OUT_BITS +: OUT_BITS].
REQ-013 SHALL have ports out_valid (output, 1) and out_ready (input, 1), output handshake.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> MAX -> EXP -> DIV -> OUT -> IDLE.
REQ-016 SHALL drive in_ready high only in IDLE; vector accepted on the edge where in_valid && in_ready, captured into an internal register, FSM to MAX.
REQ-017 MAX SHALL take exactly NUM_CLASSES cycles, one lane per cycle, comparing signed or unsigned per SIGNED_IN; max register holds the largest lane.
REQ-018 EXP SHALL take exactly NUM_CLASSES cycles: d_i = max - x_i as a (DATA_BITS+1)-bit unsigned value, clamped to 2^LUT_ADDR_BITS-1; e_i = LUT[d_i]; sum accumulates e_i.
REQ-019 LUT entry k SHALL equal round((2^EXP_BITS-1) * exp(-k/EXP_SCALE)), built at elaboration; entry 0 = 2^EXP_BITS-1.
REQ-020 sum SHALL be EXP_BITS+clog2(NUM_CLASSES) bits, never overflowing; sum >= LUT[0] > 0, so divide-by-zero cannot occur.
REQ-021 DIV SHALL compute out_i = min(2^OUT_BITS-1, floor(e_i * 2^OUT_BITS / sum)) with a restoring divider, OUT_BITS+1 cycles per lane, lanes in order 0..NUM_CLASSES-1.
REQ-022 Ties at the maximum SHALL all receive e = LUT[0].
REQ-023 out_valid SHALL rise exactly NUM_CLASSES*(OUT_BITS+3) edges after the accepting edge (44 at defaults), FSM in OUT.
REQ-024 In OUT, out_data and out_valid SHALL hold stable while out_ready is low; in_valid is ignored.
REQ-025 On the edge with out_valid && out_ready, out_valid SHALL fall and FSM to IDLE; in_ready high the following cycle; no overlap of consecutive vectors.
REQ-026 out_data SHALL be registered, updated only on the edge entering OUT.
REQ-027 in_data changes after acceptance SHALL NOT affect the result.

Reset
REQ-028 rst high SHALL immediately force FSM IDLE, out_valid 0, out_data 0, busy 0, internal accumulators 0, independent of clk.
REQ-029 in_ready SHALL be 0 while rst is high and 1 on the first cycle after deassertion.
REQ-030 Reset during any non-IDLE state SHALL abort the vector with no output produced.

Verification
REQ-031 Reset: assert rst 3 cycles -> out_valid=0, out_data=0, busy=0, in_ready=0; release -> in_ready=1 next cycle.
REQ-032 Uniform: all lanes 128, out_ready=1 -> out_valid at edge 44, every lane 64; repeat with all lanes 0 -> every lane 64.
REQ-033 Graded: lanes 0..3 = 255,192,128,64 -> out lanes 0..3 = 219,31,4,0.
REQ-034 Backpressure: out_ready=0 for 10 cycles after out_valid, new in_valid pulses -> out_data stable, in_ready=0; out_ready=1 -> handshake, IDLE next cycle.
REQ-035 Reset mid-DIV: rst at edge 20 after acceptance -> out_valid never rises; after release, uniform vector -> all 64 at edge 44.
REQ-036 Signed: SIGNED_IN=1, lanes 0..3 = 0x7F,0x80,0x80,0x80 -> lane 0 = 255 (saturated), lanes 1..3 = 0.
